// File: rtl/membus_port_arb.sv
// membus_port_arb: shares one mem0 core memory port among NPORT requesters; define ROUND_ROBIN_EN for rotating priority
module membus_port_arb #(
    parameter int NPORT   = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORT-1:0]         rq_cyc,
    input  logic [NPORT-1:0]         rd_rq,
    input  logic [NPORT-1:0]         wr_rq,
    input  logic [NPORT-1:0]         wr_rs,
    input  logic [NPORT*ADDR_W-1:0]  ma,
    input  logic [NPORT*DATA_W-1:0]  mb_in,
    output logic [NPORT-1:0]         grant,
    output logic [NPORT-1:0]         addr_ack,
    output logic [NPORT-1:0]         rd_rs,
    output logic [NPORT-1:0]         nxm,
    output logic [DATA_W-1:0]        mb_out,
    output logic                     mem_rq_cyc,
    output logic                     mem_rd_rq,
    output logic                     mem_wr_rq,
    output logic [ADDR_W-1:0]        mem_ma,
    output logic [DATA_W-1:0]        mem_mb_wr,
    output logic                     mem_wr_rs,
    input  logic                     mem_addr_ack,
    input  logic                     mem_rd_rs,
    input  logic [DATA_W-1:0]        mem_mb_rd
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, WR_WAIT, RELEASE} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     own, own_n, win, base;
    logic [TW-1:0]     timer, timer_n;
    logic [NPORT-1:0]  grant_n, addr_ack_n, rd_rs_n, nxm_n;
    logic [DATA_W-1:0] mb_out_n, mb_wr_n;
    logic [ADDR_W-1:0] ma_n;
    logic              cyc_n, rd_n, wr_n, wrs_n;
    logic              owner_rq, owner_wr_rs;
    logic [ADDR_W-1:0] ma_a [NPORT];
    logic [DATA_W-1:0] mb_a [NPORT];

    for (genvar i = 0; i < NPORT; i++) begin : g_slice
        assign ma_a[i] = ma[i*ADDR_W +: ADDR_W];
        assign mb_a[i] = mb_in[i*DATA_W +: DATA_W];
    end

    assign owner_rq    = |(rq_cyc & grant);
    assign owner_wr_rs = |(wr_rs & grant);

`ifdef ROUND_ROBIN_EN
    // search pointer: one past the most recent winner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            base <= '0;
        else if (state == IDLE && |rq_cyc)
            base <= (win == IW'(NPORT - 1)) ? '0 : win + 1'b1;
    end
`else
    assign base = '0;
`endif

    // winner: first requesting port found scanning upward from base
    always_comb begin
        win = '0;
        for (int k = NPORT - 1; k >= 0; k--)
            if (rq_cyc[IW'((int'(base) + k) % NPORT)]) win = IW'((int'(base) + k) % NPORT);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            own        <= '0;
            timer      <= '0;
            grant      <= '0;
            addr_ack   <= '0;
            rd_rs      <= '0;
            nxm        <= '0;
            mb_out     <= '0;
            mem_rq_cyc <= 1'b0;
            mem_rd_rq  <= 1'b0;
            mem_wr_rq  <= 1'b0;
            mem_ma     <= '0;
            mem_mb_wr  <= '0;
            mem_wr_rs  <= 1'b0;
        end else begin
            state      <= state_n;
            own        <= own_n;
            timer      <= timer_n;
            grant      <= grant_n;
            addr_ack   <= addr_ack_n;
            rd_rs      <= rd_rs_n;
            nxm        <= nxm_n;
            mb_out     <= mb_out_n;
            mem_rq_cyc <= cyc_n;
            mem_rd_rq  <= rd_n;
            mem_wr_rq  <= wr_n;
            mem_ma     <= ma_n;
            mem_mb_wr  <= mb_wr_n;
            mem_wr_rs  <= wrs_n;
        end
    end

    // next state and next output values; pulses default low, everything else holds
    always_comb begin
        state_n    = state;
        own_n      = own;
        timer_n    = timer;
        grant_n    = grant;
        addr_ack_n = '0;
        rd_rs_n    = '0;
        nxm_n      = '0;
        mb_out_n   = mb_out;
        cyc_n      = mem_rq_cyc;
        rd_n       = mem_rd_rq;
        wr_n       = mem_wr_rq;
        ma_n       = mem_ma;
        mb_wr_n    = mem_mb_wr;
        wrs_n      = 1'b0;
        case (state)
            IDLE: if (|rq_cyc) begin
                state_n = ADDR;
                own_n   = win;
                grant_n = NPORT'(1) << win;
                cyc_n   = 1'b1;
                rd_n    = rd_rq[win];
                wr_n    = wr_rq[win];
                ma_n    = ma_a[win];
                timer_n = '0;
            end
            ADDR: if (mem_addr_ack) begin
                cyc_n      = 1'b0;
                addr_ack_n = grant;
                state_n    = mem_rd_rq ? RD_WAIT : (mem_wr_rq ? WR_WAIT : RELEASE);
            end else if (timer == TW'(TIMEOUT - 1)) begin
                nxm_n   = grant;
                cyc_n   = 1'b0;
                state_n = RELEASE;
            end else begin
                timer_n = timer + 1'b1;
            end
            RD_WAIT: if (mem_rd_rs) begin
                mb_out_n = mem_mb_rd;
                rd_rs_n  = grant;
                state_n  = mem_wr_rq ? WR_WAIT : RELEASE;
            end
            WR_WAIT: if (owner_wr_rs || !owner_rq) begin
                mb_wr_n = owner_wr_rs ? mb_a[own] : '0;
                wrs_n   = 1'b1;
                state_n = RELEASE;
            end
            RELEASE: if (!owner_rq) begin
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == RELEASE) begin
            rd_n = 1'b0;
            wr_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_membus_port_arb.sv
// tb_membus_port_arb: randomized transaction bench for membus_port_arb against a transaction-level model
module tb_membus_port_arb;
    localparam int NPORT   = 4;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 36;
    localparam int TIMEOUT = 100;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [NPORT-1:0]        rq_cyc = '0, rd_rq = '0, wr_rq = '0, wr_rs = '0;
    logic [NPORT*ADDR_W-1:0] ma;
    logic [NPORT*DATA_W-1:0] mb_in;
    logic [NPORT-1:0]        grant, addr_ack, rd_rs, nxm;
    logic [DATA_W-1:0]       mb_out, mem_mb_wr;
    logic                    mem_rq_cyc, mem_rd_rq, mem_wr_rq, mem_wr_rs;
    logic [ADDR_W-1:0]       mem_ma;
    logic                    mem_addr_ack = 1'b0, mem_rd_rs = 1'b0;
    logic [DATA_W-1:0]       mem_mb_rd = '0;

    logic [ADDR_W-1:0] b_ma [NPORT];
    logic [DATA_W-1:0] b_mb [NPORT];
    logic              p_rd [NPORT], p_wr [NPORT], p_nack [NPORT], p_abort [NPORT];
    logic [ADDR_W-1:0] p_ma [NPORT];
    logic [DATA_W-1:0] p_mb [NPORT], p_rdata [NPORT];

    int                checks = 0, errors = 0, ptr = 0;
    logic [DATA_W-1:0] last_mb = '0;

    for (genvar i = 0; i < NPORT; i++) begin : g_bus
        assign ma[i*ADDR_W +: ADDR_W] = b_ma[i];
        assign mb_in[i*DATA_W +: DATA_W] = b_mb[i];
    end

    membus_port_arb #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rq_cyc(rq_cyc), .rd_rq(rd_rq), .wr_rq(wr_rq), .wr_rs(wr_rs),
        .ma(ma), .mb_in(mb_in), .grant(grant), .addr_ack(addr_ack), .rd_rs(rd_rs), .nxm(nxm),
        .mb_out(mb_out), .mem_rq_cyc(mem_rq_cyc), .mem_rd_rq(mem_rd_rq), .mem_wr_rq(mem_wr_rq),
        .mem_ma(mem_ma), .mem_mb_wr(mem_mb_wr), .mem_wr_rs(mem_wr_rs), .mem_addr_ack(mem_addr_ack),
        .mem_rd_rs(mem_rd_rs), .mem_mb_rd(mem_mb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd();
        return DATA_W'({$urandom, $urandom});
    endfunction

    function automatic logic [NPORT-1:0] onehot(input int w);
        onehot = '0;
        onehot[w] = 1'b1;
    endfunction

    function automatic int pick(input logic [NPORT-1:0] m);
        int s = 0;
`ifdef ROUND_ROBIN_EN
        s = ptr;
`endif
        for (int i = 0; i < NPORT; i++)
            if (m[(s + i) % NPORT]) return (s + i) % NPORT;
        return 0;
    endfunction

    task automatic set_port(input int i, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdat,
                            input logic nack, input logic abort);
        p_rd[i] = rd; p_wr[i] = wr; p_ma[i] = a; p_mb[i] = wd;
        p_rdata[i] = rdat; p_nack[i] = nack; p_abort[i] = abort;
    endtask

    // all ports in mask raise rq_cyc together; each is served to completion in model priority order
    task automatic serve(input logic [NPORT-1:0] mask);
        logic [NPORT-1:0] pend;
        int w, d, n;
        logic stray, seen, dropped;
        pend = mask;
        for (int i = 0; i < NPORT; i++) begin
            rd_rq[i] = p_rd[i];
            wr_rq[i] = p_wr[i];
            b_ma[i]  = p_ma[i];
            b_mb[i]  = p_mb[i];
        end
        rq_cyc = mask;
        while (pend != '0) begin
            w = pick(pend);
            pend[w] = 1'b0;
            ptr = (w + 1) % NPORT;
            dropped = 1'b0;
            @(negedge clk);
            chk("grant", grant, onehot(w));
            chk("mem_rq_cyc", mem_rq_cyc, 1);
            chk("mem_rd_rq", mem_rd_rq, p_rd[w]);
            chk("mem_wr_rq", mem_wr_rq, p_wr[w]);
            chk("mem_ma", mem_ma, p_ma[w]);
            b_ma[w]  = ADDR_W'($urandom);
            rd_rq[w] = ~p_rd[w];
            wr_rq[w] = ~p_wr[w];
            if (p_nack[w]) begin
                n = 0;
                seen = 1'b0;
                while (nxm == '0 && n <= TIMEOUT + 4) begin
                    @(negedge clk);
                    n++;
                    seen |= |addr_ack;
                end
                chk("nxm_latency", n, TIMEOUT);
                chk("nxm", nxm, onehot(w));
                chk("nxm_cyc", mem_rq_cyc, 0);
                chk("nxm_no_ack", seen, 0);
            end else begin
                d = $urandom_range(0, 4);
                stray = 1'b0;
                for (int k = 0; k < d; k++) begin
                    mem_rd_rs = (k == 0);
                    mem_mb_rd = rnd();
                    @(negedge clk);
                    stray |= |rd_rs;
                end
                mem_rd_rs = 1'b0;
                mem_addr_ack = 1'b1;
                @(negedge clk);
                mem_addr_ack = 1'b0;
                chk("addr_ack", addr_ack, onehot(w));
                chk("ack_cyc", mem_rq_cyc, 0);
                chk("stray_rd_rs", stray | (|rd_rs), 0);
                chk("mb_hold", mb_out, last_mb);
                if (p_rd[w]) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    mem_rd_rs = 1'b1;
                    mem_mb_rd = p_rdata[w];
                    @(negedge clk);
                    mem_rd_rs = 1'b0;
                    mem_mb_rd = rnd();
                    chk("rd_rs", rd_rs, onehot(w));
                    chk("mb_out", mb_out, p_rdata[w]);
                    chk("rd_cyc_once", mem_rq_cyc, 0);
                    last_mb = p_rdata[w];
                end
                if (p_wr[w]) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    dropped = p_abort[w];
                    if (dropped) rq_cyc[w] = 1'b0;
                    else wr_rs[w] = 1'b1;
                    @(negedge clk);
                    wr_rs = '0;
                    chk("mem_wr_rs", mem_wr_rs, 1);
                    chk("mem_mb_wr", mem_mb_wr, dropped ? '0 : p_mb[w]);
                end
            end
            chk("rel_grant", grant, onehot(w));
            chk("rel_rq", {mem_rd_rq, mem_wr_rq}, 0);
            chk("ma_hold", mem_ma, p_ma[w]);
            if (!dropped) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("hold_grant", grant, onehot(w));
                end
                rq_cyc[w] = 1'b0;
            end
            @(negedge clk);
            chk("release", grant, 0);
            chk("wr_rs_pulse", mem_wr_rs, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NPORT; i++) begin
            b_ma[i] = '0;
            b_mb[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_outputs", {grant, addr_ack, rd_rs, nxm, mb_out, mem_rq_cyc, mem_rd_rq, mem_wr_rq,
                              mem_ma, mem_mb_wr, mem_wr_rs}, 0);
        reset = 1'b1;
        @(negedge clk);
        set_port(1, 1, 0, 18'o001000, rnd(), 36'o111777222666, 0, 0);
        serve(4'b0010);
        set_port(0, 0, 1, 18'o000017, 36'o123456654321, rnd(), 0, 0);
        serve(4'b0001);
        set_port(0, 1, 0, 18'o000100, rnd(), rnd(), 0, 0);
        set_port(2, 0, 1, 18'o000200, rnd(), rnd(), 0, 0);
        serve(4'b0101);
        set_port(3, 1, 0, 18'o777777, rnd(), rnd(), 1, 0);
        serve(4'b1000);
        set_port(1, 1, 1, 18'o000005, 36'o000000000002, 36'o000000000001, 0, 0);
        serve(4'b0010);
        set_port(2, 0, 1, 18'o000042, rnd(), rnd(), 0, 1);
        serve(4'b0100);
        rq_cyc = 4'b0010;
        rd_rq  = 4'b0010;
        wr_rq  = '0;
        b_ma[1] = 18'o000333;
        @(negedge clk);
        mem_addr_ack = 1'b1;
        @(negedge clk);
        mem_addr_ack = 1'b0;
        #2 reset = 1'b0;
        #1 chk("async_reset", {grant, addr_ack, rd_rs, nxm, mb_out, mem_rq_cyc, mem_rd_rq, mem_wr_rq,
                               mem_ma, mem_mb_wr, mem_wr_rs}, 0);
        rq_cyc = '0;
        @(negedge clk);
        reset = 1'b1;
        ptr = 0;
        last_mb = '0;
        set_port(1, 1, 0, 18'o000444, rnd(), rnd(), 0, 0);
        serve(4'b0010);
        repeat (40) begin
            for (int i = 0; i < NPORT; i++)
                set_port(i, 1'($urandom), 1'($urandom), ADDR_W'($urandom), rnd(), rnd(),
                         ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
            serve(NPORT'($urandom_range(1, (1 << NPORT) - 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
